ring_hop_sequencer: RTL and testbench

- Central controller for the inter-cluster ring used by slide and reduction operations.
- Accepts one ring operation at a time. Each operation has a direction, a hop distance and a beat count per cluster.
- Executes a multi-hop slide as repeated single-hop passes. Before each pass it configures every cluster's ring router (dir, bypass, conf_valid).
- Counts beats delivered to each active cluster's slide unit and reports completion, plus an error flag, to the requester.

---
 rtl/ring_hop_sequencer_if.sv | 35 +++
 rtl/ring_hop_sequencer.sv | 155 +++++++++++++++
 tb/tb_ring_hop_sequencer.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/ring_hop_sequencer_if.sv
// Request/response, router-configuration and beat-strobe bundle of the ring hop sequencer.
// master = requester/ring side, slave = the sequencer.
interface ring_hop_sequencer_if #(
    parameter int NrClusters = 4,
    parameter int MaxBeats   = 256,
    parameter int BeatW      = $clog2(MaxBeats + 1),
    parameter int HopW       = $clog2(NrClusters)
);
    logic                  req_valid_i;
    logic                  req_ready_o;
    logic                  req_dir_i;
    logic [HopW-1:0]       req_hops_i;
    logic [BeatW-1:0]      req_beats_i;
    logic [NrClusters-1:0] req_active_i;
    logic [NrClusters-1:0] conf_valid_o;
    logic                  dir_o;
    logic [NrClusters-1:0] bypass_o;
    logic [NrClusters-1:0] sldu_rx_i;
    logic                  busy_o;
    logic                  rsp_valid_o;
    logic                  rsp_ready_i;
    logic                  rsp_err_o;

    modport master (
        output req_valid_i, req_dir_i, req_hops_i, req_beats_i, req_active_i,
        output sldu_rx_i, rsp_ready_i,
        input  req_ready_o, conf_valid_o, dir_o, bypass_o, busy_o, rsp_valid_o, rsp_err_o
    );

    modport slave (
        input  req_valid_i, req_dir_i, req_hops_i, req_beats_i, req_active_i,
        input  sldu_rx_i, rsp_ready_i,
        output req_ready_o, conf_valid_o, dir_o, bypass_o, busy_o, rsp_valid_o, rsp_err_o
    );
endinterface

// File: rtl/ring_hop_sequencer.sv
// Ring hop sequencer: runs a multi-hop slide as single-hop passes, configuring routers and counting beats.
// Latency: accept t, conf pulse t+1, counting from t+2, response the cycle after a final pass completes.
// Backpressure: one op in flight, req_ready_o only in IDLE; response held until rsp_ready_i. Watchdog: RING_HOP_SEQ_TIMEOUT_EN.
module ring_hop_sequencer #(
    parameter int NrClusters = 4,
    parameter int MaxBeats   = 256,
    parameter int BeatW      = $clog2(MaxBeats + 1),
    parameter int HopW       = $clog2(NrClusters)
`ifdef RING_HOP_SEQ_TIMEOUT_EN
    ,
    parameter int TimeoutCycles = 1024
`endif
) (
    input  logic                clk_i,
    input  logic                rst_i,
    ring_hop_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CONFIG, RUN, RESP} state_e;

    state_e                           state_q, state_d;
    logic                             dir_q, dir_d;
    logic [NrClusters-1:0]            bypass_q, bypass_d;
    logic [HopW-1:0]                  hops_q, hops_d;
    logic [BeatW-1:0]                 beats_q, beats_d;
    logic [NrClusters-1:0]            active_q, active_d;
    logic [HopW-1:0]                  pass_cnt_q, pass_cnt_d;
    logic                             err_q, err_d;
    logic [NrClusters-1:0][BeatW-1:0] rx_cnt_q, rx_cnt_d;
    logic [HopW-1:0]                  pass_nxt;
    logic                             pass_done;
`ifdef RING_HOP_SEQ_TIMEOUT_EN
    localparam int WdW = $clog2(TimeoutCycles + 1);
    logic [WdW-1:0]                   wdog_q, wdog_d;
    logic                             any_rx;
`endif

    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        bypass_d   = bypass_q;
        hops_d     = hops_q;
        beats_d    = beats_q;
        active_d   = active_q;
        pass_cnt_d = pass_cnt_q;
        err_d      = err_q;
        rx_cnt_d   = rx_cnt_q;
        pass_nxt   = pass_cnt_q + HopW'(1);
        pass_done  = 1'b1;
`ifdef RING_HOP_SEQ_TIMEOUT_EN
        wdog_d     = wdog_q;
        any_rx     = |(bus.sldu_rx_i & active_q);
`endif
        case (state_q)
            IDLE: begin
                if (bus.req_valid_i) begin
                    hops_d     = bus.req_hops_i;
                    beats_d    = bus.req_beats_i;
                    active_d   = bus.req_active_i;
                    pass_cnt_d = '0;
                    err_d      = 1'b0;
                    rx_cnt_d   = '0;
                    if (bus.req_hops_i == '0 || bus.req_active_i == '0) begin
                        state_d = RESP;
                        err_d   = (bus.req_active_i == '0);
                    end else begin
                        // Router config only changes on the way into CONFIG, so it holds across ops without passes.
                        dir_d    = bus.req_dir_i;
                        bypass_d = ~bus.req_active_i;
                        state_d  = CONFIG;
                    end
                end
            end
            CONFIG: begin
                state_d = RUN;
`ifdef RING_HOP_SEQ_TIMEOUT_EN
                wdog_d  = '0;
`endif
            end
            RUN: begin
                for (int k = 0; k < NrClusters; k++) begin
                    if (bus.sldu_rx_i[k]) begin
                        if (active_q[k] && rx_cnt_q[k] != beats_q) begin
                            rx_cnt_d[k] = rx_cnt_q[k] + BeatW'(1);
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                // Completion counts a beat landing in this same cycle.
                for (int k = 0; k < NrClusters; k++) begin
                    if (active_q[k] && rx_cnt_d[k] != beats_q) begin
                        pass_done = 1'b0;
                    end
                end
                if (pass_done) begin
                    pass_cnt_d = pass_nxt;
                    rx_cnt_d   = '0;
                    state_d    = (pass_nxt == hops_q) ? RESP : CONFIG;
                end
`ifdef RING_HOP_SEQ_TIMEOUT_EN
                wdog_d = any_rx ? '0 : wdog_q + WdW'(1);
                if (!pass_done && !any_rx && wdog_d == WdW'(TimeoutCycles)) begin
                    state_d  = RESP;
                    err_d    = 1'b1;
                    rx_cnt_d = '0;
                end
`endif
            end
            RESP: begin
                if (bus.rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            dir_q      <= 1'b0;
            bypass_q   <= '0;
            hops_q     <= '0;
            beats_q    <= '0;
            active_q   <= '0;
            pass_cnt_q <= '0;
            err_q      <= 1'b0;
            rx_cnt_q   <= '0;
`ifdef RING_HOP_SEQ_TIMEOUT_EN
            wdog_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            bypass_q   <= bypass_d;
            hops_q     <= hops_d;
            beats_q    <= beats_d;
            active_q   <= active_d;
            pass_cnt_q <= pass_cnt_d;
            err_q      <= err_d;
            rx_cnt_q   <= rx_cnt_d;
`ifdef RING_HOP_SEQ_TIMEOUT_EN
            wdog_q     <= wdog_d;
`endif
        end
    end

    assign bus.req_ready_o  = (state_q == IDLE);
    assign bus.busy_o       = (state_q != IDLE);
    assign bus.conf_valid_o = {NrClusters{state_q == CONFIG}};
    assign bus.dir_o        = dir_q;
    assign bus.bypass_o     = bypass_q;
    assign bus.rsp_valid_o  = (state_q == RESP);
    assign bus.rsp_err_o    = err_q;
endmodule

// File: tb/tb_ring_hop_sequencer.sv
// Directed bench for ring_hop_sequencer: vector table of back-to-back ops plus hand-built multi-cycle sequences.
module tb_ring_hop_sequencer;
    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk_i = ~clk_i;

    ring_hop_sequencer_if #(.NrClusters(4), .MaxBeats(256)) bus ();

`ifdef RING_HOP_SEQ_TIMEOUT_EN
    ring_hop_sequencer #(.NrClusters(4), .MaxBeats(256), .TimeoutCycles(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .bus(bus));
`else
    ring_hop_sequencer #(.NrClusters(4), .MaxBeats(256)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .bus(bus));
`endif

    typedef struct {
        logic       dir;
        logic [1:0] hops;
        logic [8:0] beats;
        logic [3:0] active;
        int         exp_confs;
        logic       exp_dir;
        logic [3:0] exp_bypass;
        logic       exp_err;
        int         exp_lat;   // edges from accept edge (inclusive) to first rsp_valid_o sample
        int         hold;      // cycles rsp_ready_i stays low
    } vec_t;

    vec_t       vecs [7];
    logic [3:0] pat  [32];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic send_req(input logic dir, input logic [1:0] hops, input logic [8:0] beats,
                            input logic [3:0] act);
        bus.req_valid_i  = 1'b1;
        bus.req_dir_i    = dir;
        bus.req_hops_i   = hops;
        bus.req_beats_i  = beats;
        bus.req_active_i = act;
        @(negedge clk_i);
        bus.req_valid_i  = 1'b0;
    endtask

    task automatic finish_rsp(input string name, input logic exp_err, input int hold);
        logic held_ok;
        held_ok = 1'b1;
        for (int i = 0; i < hold; i++) begin
            if (!(bus.rsp_valid_o && bus.rsp_err_o == exp_err && !bus.req_ready_o)) held_ok = 1'b0;
            @(negedge clk_i);
        end
        check({name, "_rsp_hold"},
              32'(held_ok ? {bus.req_ready_o, bus.rsp_valid_o, bus.rsp_err_o} : 3'b111),
              32'({1'b0, 1'b1, exp_err}));
        bus.rsp_ready_i = 1'b1;
        @(negedge clk_i);
        bus.rsp_ready_i = 1'b0;
        check({name, "_back_idle"}, 32'({bus.req_ready_o, bus.busy_o, bus.rsp_valid_o}), 32'(3'b100));
    endtask

    task automatic run_vec(input int idx);
        vec_t v;
        int   edges, confs, pend;
        logic conf_bad;
        string nm;
        v = vecs[idx];
        nm = $sformatf("vec%0d", idx);
        edges = 1; confs = 0; pend = 0; conf_bad = 1'b0;
        send_req(v.dir, v.hops, v.beats, v.active);
        while (!bus.rsp_valid_o && edges < 200) begin
            if (pend > 0) begin
                bus.sldu_rx_i = v.active;
                pend--;
            end else begin
                bus.sldu_rx_i = '0;
            end
            if (bus.conf_valid_o != '0) begin
                confs++;
                if (bus.conf_valid_o != 4'hF) conf_bad = 1'b1;
                pend = int'(v.beats);
            end
            @(negedge clk_i);
            edges++;
        end
        bus.sldu_rx_i = '0;
        check({nm, "_latency"}, 32'(edges), 32'(v.exp_lat));
        check({nm, "_conf_pulses"}, 32'(conf_bad ? confs + 100 : confs), 32'(v.exp_confs));
        check({nm, "_dir_bypass"}, 32'({bus.dir_o, bus.bypass_o}), 32'({v.exp_dir, v.exp_bypass}));
        finish_rsp(nm, v.exp_err, v.hold);
    endtask

    // Drives pat[0..npat-1] on sldu_rx_i starting with the first RUN cycle.
    task automatic run_seq(input string name, input logic dir, input logic [1:0] hops,
                           input logic [8:0] beats, input logic [3:0] act, input int npat,
                           input int exp_lat, input logic exp_err, input int hold);
        int   edges, ci;
        logic started;
        edges = 1; ci = 0; started = 1'b0;
        send_req(dir, hops, beats, act);
        while (!bus.rsp_valid_o && edges < 200) begin
            if (started && ci < npat) begin
                bus.sldu_rx_i = pat[ci];
                ci++;
            end else begin
                bus.sldu_rx_i = '0;
            end
            if (bus.conf_valid_o != '0) started = 1'b1;
            @(negedge clk_i);
            edges++;
        end
        bus.sldu_rx_i = '0;
        check({name, "_latency"}, 32'(edges), 32'(exp_lat));
        finish_rsp(name, exp_err, hold);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, want summary");
        $fatal(1, "timeout");
    end

    initial begin
        logic seen_rsp;
        //           dir   hops  beats  act    confs dir   byp    err   lat hold
        vecs[0] = '{1'b1, 2'd1, 9'd4, 4'hF,  1,   1'b1, 4'h0,  1'b0,  6,  0};
        vecs[1] = '{1'b0, 2'd3, 9'd2, 4'h5,  3,   1'b0, 4'hA,  1'b0, 10,  2};
        vecs[2] = '{1'b1, 2'd0, 9'd3, 4'hF,  0,   1'b0, 4'hA,  1'b0,  1,  1};
        vecs[3] = '{1'b1, 2'd2, 9'd3, 4'h0,  0,   1'b0, 4'hA,  1'b1,  1,  3};
        vecs[4] = '{1'b1, 2'd2, 9'd0, 4'h3,  2,   1'b1, 4'hC,  1'b0,  5,  0};
        vecs[5] = '{1'b0, 2'd2, 9'd1, 4'h8,  2,   1'b0, 4'h7,  1'b0,  5,  1};
        vecs[6] = '{1'b1, 2'd3, 9'd3, 4'hF,  3,   1'b1, 4'h0,  1'b0, 13,  0};

        bus.req_valid_i  = 1'b0;
        bus.req_dir_i    = 1'b0;
        bus.req_hops_i   = '0;
        bus.req_beats_i  = '0;
        bus.req_active_i = '0;
        bus.sldu_rx_i    = '0;
        bus.rsp_ready_i  = 1'b0;
        rst_i = 1'b1;
        repeat (3) @(negedge clk_i);
        // {req_ready, busy, conf_valid, dir, bypass, rsp_valid, rsp_err}
        check("reset_outputs", 32'({bus.req_ready_o, bus.busy_o, bus.conf_valid_o, bus.dir_o,
                                    bus.bypass_o, bus.rsp_valid_o, bus.rsp_err_o}), 32'(13'h1000));
        rst_i = 1'b0;
        repeat (2) @(negedge clk_i);
        check("idle_outputs", 32'({bus.req_ready_o, bus.busy_o, bus.conf_valid_o, bus.dir_o,
                                   bus.bypass_o, bus.rsp_valid_o, bus.rsp_err_o}), 32'(13'h1000));

        // Staggered arrival: each cluster gets 4 beats, last one in RUN cycle 7.
        pat[0] = 4'h1; pat[1] = 4'h3; pat[2] = 4'h7; pat[3] = 4'hF;
        pat[4] = 4'hE; pat[5] = 4'hC; pat[6] = 4'h8;
        run_seq("stagger", 1'b1, 2'd1, 9'd4, 4'hF, 7, 9, 1'b0, 0);
        check("stagger_cfg", 32'({bus.dir_o, bus.bypass_o}), 32'({1'b1, 4'h0}));

        for (int i = 0; i < 7; i++) run_vec(i);

        // Surplus beat on cluster 0 and a beat on inactive cluster 1: completes, flags error.
        pat[0] = 4'h1; pat[1] = 4'h3; pat[2] = 4'h1; pat[3] = 4'h4; pat[4] = 4'h4;
        run_seq("extra_beat", 1'b0, 2'd1, 9'd2, 4'h5, 5, 7, 1'b1, 1);

        // Reset in the middle of RUN: silent abort.
        send_req(1'b1, 2'd1, 9'd4, 4'hF);
        bus.sldu_rx_i = '0;
        @(negedge clk_i);
        bus.sldu_rx_i = 4'hF;
        @(negedge clk_i);
        bus.sldu_rx_i = '0;
        rst_i = 1'b1;
        @(negedge clk_i);
        check("midrun_reset", 32'({bus.req_ready_o, bus.busy_o, bus.conf_valid_o, bus.dir_o,
                                   bus.bypass_o, bus.rsp_valid_o, bus.rsp_err_o}), 32'(13'h1000));
        rst_i = 1'b0;
        seen_rsp = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_i);
            if (bus.rsp_valid_o || bus.busy_o) seen_rsp = 1'b1;
        end
        check("midrun_no_rsp", 32'(seen_rsp), 32'(0));
        run_vec(0);

`ifdef RING_HOP_SEQ_TIMEOUT_EN
        // Cluster 2 misses its 4th beat; 16 idle RUN cycles later the op aborts with error.
        pat[0] = 4'hF; pat[1] = 4'hF; pat[2] = 4'hF; pat[3] = 4'hB;
        run_seq("watchdog", 1'b1, 2'd1, 9'd4, 4'hF, 4, 22, 1'b1, 5);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
